scrypt_result_check: RTL

//  Consumes the 32-byte scrypt digest from the final PBKDF2 stage, pairs it with the nonce it was issued
//  for, and reports hits against the share target. Nonces enter an in-order FIFO on job issue; each

---
 rtl/scrypt_result_check.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/scrypt_result_check.sv
// Pairs scrypt digests with their issued nonces (in-order FIFO), compares each digest
// against the share target in a two-stage pipeline and holds hits for the host side.
module scrypt_result_check #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         job_start,
    input  logic [31:0]  job_nonce,
    output logic         fifo_full,
    input  logic [255:0] hash_in,
    input  logic         hash_done,
    input  logic [255:0] target,
    output logic         found_valid,
    input  logic         found_ready,
    output logic [31:0]  found_nonce,
    output logic [255:0] found_hash,
    output logic [31:0]  hash_count,
    output logic         err_overflow,
    output logic         err_underflow,
    output logic         err_dropped
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic {
        OUT_EMPTY,
        OUT_FULL
    } out_state_e;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          fifo_empty;
    logic          push, pop;

    logic          s1_valid_q;
    logic [31:0]   s1_nonce_q;
    logic [255:0]  s1_hash_q;
    logic          s1_hi_lt_q, s1_hi_eq_q, s1_lo_le_q;
    logic          s2_hit;

    out_state_e    state_q, state_d;
    logic          load;
    logic          drop;
    logic [31:0]   found_nonce_q;
    logic [255:0]  found_hash_q;
    logic [31:0]   hash_count_q;
    logic          err_overflow_q, err_underflow_q, err_dropped_q;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (AW+1)'(DEPTH));
    // Both flags come from the pre-cycle occupancy: a full FIFO rejects even if
    // a pop happens, and an empty FIFO cannot serve a pop even if a push happens.
    assign push = job_start & ~fifo_full;
    assign pop  = hash_done & ~fifo_empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= job_nonce;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    // Stage 1: split the 256-bit compare into upper/lower halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_nonce_q <= '0;
            s1_hash_q  <= '0;
            s1_hi_lt_q <= 1'b0;
            s1_hi_eq_q <= 1'b0;
            s1_lo_le_q <= 1'b0;
        end else begin
            s1_valid_q <= pop;
            s1_nonce_q <= mem_q[rd_ptr_q];
            s1_hash_q  <= hash_in;
            s1_hi_lt_q <= hash_in[255:128] <  target[255:128];
            s1_hi_eq_q <= hash_in[255:128] == target[255:128];
            s1_lo_le_q <= hash_in[127:0]   <= target[127:0];
        end
    end

    assign s2_hit = s1_valid_q & (s1_hi_lt_q | (s1_hi_eq_q & s1_lo_le_q));

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (s2_hit) begin
                    load    = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (found_ready) begin
                    load    = s2_hit;
                    state_d = s2_hit ? OUT_FULL : OUT_EMPTY;
                end else if (s2_hit) begin
                    drop = 1'b1;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= OUT_EMPTY;
            found_nonce_q   <= '0;
            found_hash_q    <= '0;
            hash_count_q    <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
            err_dropped_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                found_nonce_q <= s1_nonce_q;
                found_hash_q  <= s1_hash_q;
            end
            if (s1_valid_q) hash_count_q <= hash_count_q + 32'd1;
            if (job_start & fifo_full)  err_overflow_q  <= 1'b1;
            if (hash_done & fifo_empty) err_underflow_q <= 1'b1;
            if (drop)                   err_dropped_q   <= 1'b1;
        end
    end

    assign found_valid   = (state_q == OUT_FULL);
    assign found_nonce   = found_nonce_q;
    assign found_hash    = found_hash_q;
    assign hash_count    = hash_count_q;
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
    assign err_dropped   = err_dropped_q;

endmodule
